reg_check_monitor: RTL and testbench

Synthesizable, parametrised register-file checker for the RISC-V core. It snoops the register writeback port, keeps a shadow copy of the architectural registers, and steps through a programmed table of checkpoints. Each checkpoint is either "wait until reg == value" or "reg must equal value now". It adds a global timeout, so the core self-reports pass, fail or timeout on FPGA without a testbench. It sits beside the CPU and is driven only by the writeback bus and a small config port.

---
 rtl/reg_check_monitor_pkg.sv | 30 +++
 rtl/reg_check_monitor_if.sv | 43 ++++
 rtl/reg_check_monitor_shadow.sv | 27 ++
 rtl/reg_check_monitor.sv | 132 +++++++++++++
 tb/tb_reg_check_monitor.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_check_monitor_pkg.sv
// Shared types for the register-file checkpoint monitor.
// State encoding, checkpoint modes and the table entry layout.
package rcm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_e;

    typedef enum logic {
        MODE_WAIT  = 1'b0,
        MODE_CHECK = 1'b1
    } mode_e;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_REG_AW    = 5;
    localparam int DEF_TESTNUM_W = 11;

    // Entry layout for the default core configuration
    typedef struct packed {
        mode_e                     mode;
        logic [DEF_REG_AW-1:0]     rg;
        logic [DEF_XLEN-1:0]       value;
        logic [DEF_TESTNUM_W-1:0]  test_num;
    } rcm_entry_t;

endpackage

// File: rtl/reg_check_monitor_if.sv
// Writeback snoop, table config and result bundle of the monitor.
// master = core/host side, slave = monitor side.
interface reg_check_monitor_if #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int IDX_W     = 3,
    parameter int TESTNUM_W = 11
);
    logic                 wb_en;
    logic [REG_AW-1:0]    wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic                 cfg_mode;
    logic [REG_AW-1:0]    cfg_reg;
    logic [XLEN-1:0]      cfg_value;
    logic [TESTNUM_W-1:0] cfg_test_num;
    logic [IDX_W:0]       cfg_count;
    logic                 start;
    logic                 busy;
    logic                 pass;
    logic                 fail;
    logic                 timeout;
    logic [TESTNUM_W-1:0] fail_test_num;
    logic [XLEN-1:0]      fail_got;
    logic [IDX_W:0]       cur_idx;

    modport master (
        output wb_en, wb_addr, wb_data,
        output cfg_we, cfg_idx, cfg_mode, cfg_reg,
        output cfg_value, cfg_test_num, cfg_count, start,
        input  busy, pass, fail, timeout,
        input  fail_test_num, fail_got, cur_idx
    );

    modport slave (
        input  wb_en, wb_addr, wb_data,
        input  cfg_we, cfg_idx, cfg_mode, cfg_reg,
        input  cfg_value, cfg_test_num, cfg_count, start,
        output busy, pass, fail, timeout,
        output fail_test_num, fail_got, cur_idx
    );
endinterface

// File: rtl/reg_check_monitor_shadow.sv
// Shadow copy of the architectural register file.
// One write port, one combinational read port, x0 reads as zero.
module reg_shadow #(
    parameter  int XLEN     = 32,
    parameter  int NUM_REGS = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);
    logic [XLEN-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == '0) ? '0 : mem[raddr];
endmodule

// File: rtl/reg_check_monitor.sv
// Checkpoint monitor: walks a table of WAIT/CHECK entries against
// the shadow registers and reports pass, fail or timeout.
module reg_check_monitor #(
    parameter  int XLEN           = 32,
    parameter  int NUM_REGS       = 32,
    parameter  int NUM_CHECKS     = 8,
    parameter  int TIMEOUT_CYCLES = 1000,
    parameter  int TESTNUM_W      = 11,
    localparam int REG_AW         = $clog2(NUM_REGS),
    localparam int IDX_W          = $clog2(NUM_CHECKS),
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic               clk,
    input logic               rst,
    reg_check_monitor_if.slave bus
);
    import rcm_pkg::*;

    typedef struct packed {
        mode_e                mode;
        logic [REG_AW-1:0]    rg;
        logic [XLEN-1:0]      value;
        logic [TESTNUM_W-1:0] test_num;
    } tbl_entry_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    tbl_entry_t           tbl [NUM_CHECKS];
    tbl_entry_t           e;
    state_e               state, state_nxt;
    logic [IDX_W:0]       idx, idx_nxt, idx_inc;
    logic [IDX_W:0]       n, n_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [TESTNUM_W-1:0] ftn, ftn_nxt;
    logic [XLEN-1:0]      fgot, fgot_nxt;
    logic [XLEN-1:0]      rd;
    logic                 hit;

    assign e       = tbl[idx[IDX_W-1:0]];
    assign idx_inc = idx + 1'b1;
    assign hit     = (rd == e.value);

    reg_shadow #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.wb_en),
        .waddr (bus.wb_addr),
        .wdata (bus.wb_data),
        .raddr (e.rg),
        .rdata (rd)
    );

    // Table is frozen while a run is in progress
    always_ff @(posedge clk) begin
        if (bus.cfg_we && state != ST_RUN) begin
            tbl[bus.cfg_idx] <= '{
                mode:     mode_e'(bus.cfg_mode),
                rg:       bus.cfg_reg,
                value:    bus.cfg_value,
                test_num: bus.cfg_test_num
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            n     <= '0;
            cnt   <= '0;
            ftn   <= '0;
            fgot  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            n     <= n_nxt;
            cnt   <= cnt_nxt;
            ftn   <= ftn_nxt;
            fgot  <= fgot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        n_nxt     = n;
        cnt_nxt   = cnt;
        ftn_nxt   = ftn;
        fgot_nxt  = fgot;
        unique case (state)
            ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (bus.start) begin
                    n_nxt     = bus.cfg_count;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    ftn_nxt   = '0;
                    fgot_nxt  = '0;
                    state_nxt = (bus.cfg_count == '0) ? ST_PASS : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt < CNT_SAT) cnt_nxt = cnt + 1'b1;
                // Fail beats completion beats timeout
                if (hit) begin
                    idx_nxt = idx_inc;
                    if (idx_inc == n) state_nxt = ST_PASS;
                end else if (e.mode == MODE_CHECK) begin
                    state_nxt = ST_FAIL;
                    ftn_nxt   = e.test_num;
                    fgot_nxt  = rd;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = ST_TIMEOUT;
                    ftn_nxt   = e.test_num;
                    fgot_nxt  = rd;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy          = (state == ST_RUN);
    assign bus.pass          = (state == ST_PASS);
    assign bus.fail          = (state == ST_FAIL);
    assign bus.timeout       = (state == ST_TIMEOUT);
    assign bus.fail_test_num = ftn;
    assign bus.fail_got      = fgot;
    assign bus.cur_idx       = idx;
endmodule

// File: tb/tb_reg_check_monitor.sv
// Directed bench for reg_check_monitor with hand-derived expectations.
// Uses a short timeout so the timeout path is reachable quickly.
module tb_reg_check_monitor;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int IDX_W = 3;
    localparam int TNW = 11;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    reg_check_monitor_if #(
        .XLEN(XLEN), .REG_AW(REG_AW),
        .IDX_W(IDX_W), .TESTNUM_W(TNW)
    ) bif ();

    reg_check_monitor #(
        .XLEN(XLEN), .NUM_REGS(32), .NUM_CHECKS(8),
        .TIMEOUT_CYCLES(50), .TESTNUM_W(TNW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int idx, input bit mode,
                        input int rg, input logic [31:0] val,
                        input int tn);
        bif.cfg_we       = 1'b1;
        bif.cfg_idx      = IDX_W'(idx);
        bif.cfg_mode     = mode;
        bif.cfg_reg      = REG_AW'(rg);
        bif.cfg_value    = val;
        bif.cfg_test_num = TNW'(tn);
        tick();
        bif.cfg_we = 1'b0;
    endtask

    task automatic wb(input int rg, input logic [31:0] val);
        bif.wb_en   = 1'b1;
        bif.wb_addr = REG_AW'(rg);
        bif.wb_data = val;
        tick();
        bif.wb_en = 1'b0;
    endtask

    task automatic go(input int count);
        bif.cfg_count = (IDX_W+1)'(count);
        bif.start     = 1'b1;
        tick();
        bif.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bif.wb_en = 0; bif.wb_addr = '0; bif.wb_data = '0;
        bif.cfg_we = 0; bif.cfg_idx = '0; bif.cfg_mode = 0;
        bif.cfg_reg = '0; bif.cfg_value = '0;
        bif.cfg_test_num = '0; bif.cfg_count = '0; bif.start = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", 64'(bif.busy), 64'd0);
        chk("rst_pass", 64'(bif.pass), 64'd0);
        chk("rst_fail", 64'(bif.fail), 64'd0);
        chk("rst_tmo", 64'(bif.timeout), 64'd0);
        chk("rst_ftn", 64'(bif.fail_test_num), 64'd0);
        chk("rst_got", 64'(bif.fail_got), 64'd0);
        chk("rst_idx", 64'(bif.cur_idx), 64'd0);

        // basic WAIT then CHECK
        prog(0, 0, 10, 32'd100, 5);
        prog(1, 0, 20, 32'd1, 0);
        prog(2, 1, 1, 32'd300, 1);
        go(3);
        chk("t1_busy", 64'(bif.busy), 64'd1);
        wb(1, 32'd300);
        wb(10, 32'd100);
        wb(20, 32'd1);
        chk("t1_idx1", 64'(bif.cur_idx), 64'd1);
        tick();
        chk("t1_pass_early", 64'(bif.pass), 64'd0);
        chk("t1_idx2", 64'(bif.cur_idx), 64'd2);
        tick();
        chk("t1_pass", 64'(bif.pass), 64'd1);
        chk("t1_busy_lo", 64'(bif.busy), 64'd0);
        tick();
        tick();
        chk("t1_pass_hold", 64'(bif.pass), 64'd1);

        // CHECK mismatch on the last entry
        prog(0, 0, 20, 32'd2, 0);
        prog(1, 1, 1, 32'd500, 2);
        prog(2, 1, 2, 32'd100, 3);
        go(3);
        chk("t2_pass_clr", 64'(bif.pass), 64'd0);
        wb(1, 32'd500);
        wb(2, 32'd99);
        wb(20, 32'd2);
        tick();
        tick();
        chk("t2_fail_early", 64'(bif.fail), 64'd0);
        tick();
        chk("t2_fail", 64'(bif.fail), 64'd1);
        chk("t2_ftn", 64'(bif.fail_test_num), 64'd3);
        chk("t2_got", 64'(bif.fail_got), 64'd99);
        chk("t2_pass", 64'(bif.pass), 64'd0);
        chk("t2_idx", 64'(bif.cur_idx), 64'd2);

        // timeout, 50 RUN cycles
        prog(0, 0, 5, 32'd7, 4);
        go(1);
        chk("t3_busy", 64'(bif.busy), 64'd1);
        chk("t3_fail_clr", 64'(bif.fail), 64'd0);
        for (int i = 0; i < 49; i++) tick();
        chk("t3_tmo_early", 64'(bif.timeout), 64'd0);
        tick();
        chk("t3_tmo", 64'(bif.timeout), 64'd1);
        chk("t3_busy_lo", 64'(bif.busy), 64'd0);
        chk("t3_got", 64'(bif.fail_got), 64'd0);
        chk("t3_ftn", 64'(bif.fail_test_num), 64'd4);

        // x0 stays zero
        wb(0, 32'hFFFF_FFFF);
        prog(0, 1, 0, 32'd0, 6);
        go(1);
        tick();
        chk("t4_x0_pass", 64'(bif.pass), 64'd1);
        chk("t4_x0_fail", 64'(bif.fail), 64'd0);

        // write and CHECK of x3 on the same edge sees the old value
        prog(0, 1, 3, 32'd9, 7);
        go(1);
        bif.wb_en = 1'b1; bif.wb_addr = 5'd3; bif.wb_data = 32'd9;
        tick();
        bif.wb_en = 1'b0;
        chk("t4_same_fail", 64'(bif.fail), 64'd1);
        chk("t4_same_got", 64'(bif.fail_got), 64'd0);
        chk("t4_same_ftn", 64'(bif.fail_test_num), 64'd7);

        // reset mid-RUN
        prog(0, 0, 5, 32'd7, 4);
        go(1);
        tick();
        chk("t5_busy", 64'(bif.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_busy", 64'(bif.busy), 64'd0);
        chk("t5_rst_flags",
            64'({bif.pass, bif.fail, bif.timeout}), 64'd0);
        chk("t5_rst_idx", 64'(bif.cur_idx), 64'd0);
        chk("t5_rst_ftn", 64'(bif.fail_test_num), 64'd0);

        // shadow was cleared by reset: x3 is 0 again
        prog(0, 1, 3, 32'd0, 8);
        go(1);
        tick();
        chk("t5_shadow_clr", 64'(bif.pass), 64'd1);

        // empty table passes one cycle after start
        go(0);
        chk("t5_n0_pass", 64'(bif.pass), 64'd1);
        chk("t5_n0_busy", 64'(bif.busy), 64'd0);

        // cfg_we during RUN is dropped
        prog(0, 0, 5, 32'd7, 4);
        go(1);
        prog(0, 0, 5, 32'd0, 9);
        tick();
        tick();
        chk("t6_still_busy", 64'(bif.busy), 64'd1);
        chk("t6_idx", 64'(bif.cur_idx), 64'd0);
        wb(5, 32'd7);
        tick();
        chk("t6_pass", 64'(bif.pass), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
